// File: rtl/branch_resolve_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_resolve_queue: tracks predicted control-flow ops to in-order      |
// | commit, trains the predictor and raises mispredict flush/redirect.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module branch_resolve_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             ext_flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_pc,
  input  logic             enq_pred_taken,
  input  logic [31:0]      enq_pred_pc,
  input  logic [TAG_W-1:0] enq_tag,
  output logic             full,
  output logic [PTR_W:0]   count,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             rob_commit_pc_arrived,
  output logic [31:0]      rob_commit_pc,
  output logic             hit_res,
  output logic             flush,
  output logic [31:0]      redirect_pc
);

  localparam logic [PTR_W:0] c_full_count = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  logic [31:0]      pc_q      [DEPTH];
  logic [31:0]      pc_d      [DEPTH];
  logic [31:0]      pred_pc_q [DEPTH];
  logic [31:0]      pred_pc_d [DEPTH];
  logic [31:0]      act_pc_q  [DEPTH];
  logic [31:0]      act_pc_d  [DEPTH];
  logic [TAG_W-1:0] tag_q     [DEPTH];
  logic [TAG_W-1:0] tag_d     [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             arrived_q, arrived_d;
  logic [31:0]      commit_pc_q, commit_pc_d;
  logic             hit_q, hit_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;

  logic             w_full;
  logic             w_commit;
  logic             w_mispredict;
  logic             w_enq_ok;
  logic             w_res_hit;
  logic [PTR_W-1:0] w_res_idx;
  logic             w_unused;

  // The prediction is fully captured by enq_pred_pc; the direction bit is redundant here.
  assign w_unused = enq_pred_taken;

  assign w_full       = (count_q == c_full_count);
  assign w_commit     = valid_q[head_q] && resolved_q[head_q];
  assign w_mispredict = w_commit && (act_pc_q[head_q] != pred_pc_q[head_q]);
  assign w_enq_ok     = enq_valid && !w_full;

  // Lowest matching index wins should software ever issue duplicate tags.
  always_comb begin
    w_res_hit = 1'b0;
    w_res_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_res_hit && valid_q[i] && !resolved_q[i] && (tag_q[i] == res_tag)) begin
        w_res_hit = 1'b1;
        w_res_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    valid_d     = valid_q;
    resolved_d  = resolved_q;
    pc_d        = pc_q;
    pred_pc_d   = pred_pc_q;
    act_pc_d    = act_pc_q;
    tag_d       = tag_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    arrived_d   = 1'b0;
    commit_pc_d = commit_pc_q;
    hit_d       = hit_q;
    flush_d     = 1'b0;
    redirect_d  = redirect_q;

    if (ext_flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy) begin
      if (w_commit) begin
        arrived_d   = 1'b1;
        commit_pc_d = pc_q[head_q];
        hit_d       = !w_mispredict;
      end
      if (w_mispredict) begin
        // Everything younger than a mispredicted branch is wrong-path work.
        flush_d    = 1'b1;
        redirect_d = act_pc_q[head_q];
        valid_d    = '0;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
      end else begin
        if (res_valid && w_res_hit) begin
          resolved_d[w_res_idx] = 1'b1;
          act_pc_d[w_res_idx]   = res_taken ? res_target : (pc_q[w_res_idx] + 32'd4);
        end
        if (w_commit) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + 1'b1;
        end
        if (w_enq_ok) begin
          valid_d[tail_q]    = 1'b1;
          resolved_d[tail_q] = 1'b0;
          pc_d[tail_q]       = enq_pc;
          pred_pc_d[tail_q]  = enq_pred_pc;
          tag_d[tail_q]      = enq_tag;
          tail_d             = tail_q + 1'b1;
        end
        count_d = count_q + (PTR_W+1)'(w_enq_ok) - (PTR_W+1)'(w_commit);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      resolved_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      arrived_q   <= 1'b0;
      commit_pc_q <= '0;
      hit_q       <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      arrived_q   <= arrived_d;
      commit_pc_q <= commit_pc_d;
      hit_q       <= hit_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
    end
  end

  // Payload is only ever read behind a valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    pc_q      <= pc_d;
    pred_pc_q <= pred_pc_d;
    act_pc_q  <= act_pc_d;
    tag_q     <= tag_d;
  end

  assign full                  = w_full;
  assign count                 = count_q;
  assign rob_commit_pc_arrived = arrived_q;
  assign rob_commit_pc         = commit_pc_q;
  assign hit_res               = hit_q;
  assign flush                 = flush_q;
  assign redirect_pc           = redirect_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_resolve_queue: directed scenarios plus randomized traffic      |
// | against a queue-based reference model. Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module tb_branch_resolve_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        ext_flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_pc = '0;
  logic        enq_pred_taken = 1'b0;
  logic [31:0] enq_pred_pc = '0;
  logic [3:0]  enq_tag = '0;
  logic        full;
  logic [4:0]  count;
  logic        res_valid = 1'b0;
  logic [3:0]  res_tag = '0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        rob_commit_pc_arrived;
  logic [31:0] rob_commit_pc;
  logic        hit_res;
  logic        flush;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  branch_resolve_queue #(.DEPTH(16), .PTR_W(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .ext_flush(ext_flush),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken),
    .enq_pred_pc(enq_pred_pc), .enq_tag(enq_tag), .full(full), .count(count),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .res_target(res_target), .rob_commit_pc_arrived(rob_commit_pc_arrived),
    .rob_commit_pc(rob_commit_pc), .hit_res(hit_res), .flush(flush),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Reference model: program-order queue of in-flight branches.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
    logic [3:0]  tag;
    bit          res;
    logic [31:0] act;
  } ent_t;

  ent_t        mq[$];
  bit          e_arr;
  bit          e_flush;
  bit          e_hit;
  logic [31:0] e_pc;
  logic [31:0] e_redir;

  task automatic model_reset();
    mq.delete();
    e_arr = 0; e_flush = 0; e_hit = 0; e_pc = '0; e_redir = '0;
  endtask

  task automatic model_edge();
    bit   was_full;
    bit   commit;
    bit   mis;
    ent_t n;
    if (ext_flush) begin
      mq.delete(); e_arr = 0; e_flush = 0;
    end else if (!rdy) begin
      e_arr = 0; e_flush = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      commit   = (mq.size() > 0) && mq[0].res;
      mis      = commit && (mq[0].act != mq[0].pred);
      e_arr    = commit;
      e_flush  = mis;
      if (commit) begin e_pc = mq[0].pc; e_hit = !mis; end
      if (mis) begin
        e_redir = mq[0].act;
        mq.delete();
      end else begin
        if (res_valid) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].res && mq[i].tag == res_tag) begin
              mq[i].res = 1;
              mq[i].act = res_taken ? res_target : mq[i].pc + 32'd4;
              break;
            end
          end
        end
        if (commit) void'(mq.pop_front());
        if (enq_valid && !was_full) begin
          n.pc = enq_pc; n.pred = enq_pred_pc; n.tag = enq_tag; n.res = 0; n.act = '0;
          mq.push_back(n);
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input bit v, input logic [31:0] pc, input logic [31:0] pred, input logic [3:0] tag);
    enq_valid = v; enq_pc = pc; enq_pred_pc = pred; enq_tag = tag;
    enq_pred_taken = (pred != pc + 32'd4);
  endtask

  task automatic set_res(input bit v, input logic [3:0] tag, input bit tk, input logic [31:0] tgt);
    res_valid = v; res_tag = tag; res_taken = tk; res_target = tgt;
  endtask

  task automatic test_reset();
    #7;
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %0b want 0", full); end
    n_tests++; if ({rob_commit_pc_arrived, hit_res, flush} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %03b want 000", {rob_commit_pc_arrived, hit_res, flush}); end
    n_tests++; if ({rob_commit_pc, redirect_pc} !== 64'd0) begin n_fail++; $display("FAIL rst_pcs: got %h want 0", {rob_commit_pc, redirect_pc}); end
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    // Six entries, head commits, so five are queued while a pulse is high.
    for (int i = 0; i < 6; i++) begin
      set_enq(1, 32'h600 + 32'(4*i), 32'h604 + 32'(4*i), 4'(8+i));
      step();
    end
    set_enq(0, 0, 0, 0);
    set_res(1, 4'd8, 0, 0); step(); set_res(0, 0, 0, 0);
    step();
    n_tests++; if (rob_commit_pc_arrived !== 1'b1 || count !== 5'd5) begin n_fail++; $display("FAIL rst_pre: got arr=%0b cnt=%0d want arr=1 cnt=5", rob_commit_pc_arrived, count); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d want 0", count); end
    n_tests++; if (rob_commit_pc_arrived !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL rst_async_pulse: got arr=%0b fl=%0b want 0 0", rob_commit_pc_arrived, flush); end
    model_reset();
    #1 rst_n = 1'b1;
    set_res(1, 4'd9, 0, 0); step(); set_res(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (rob_commit_pc_arrived !== 1'b0) begin n_fail++; $display("FAIL rst_stale_commit: got arr=%0b want 0", rob_commit_pc_arrived); end
    end
  endtask

  task automatic test_not_taken();
    set_enq(1, 32'h100, 32'h104, 4'd3); step(); set_enq(0, 0, 0, 0);
    n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL nt_count: got %0d want 1", count); end
    set_res(1, 4'd3, 0, 32'hDEAD_BEE0); step(); set_res(0, 0, 0, 0);
    n_tests++; if (rob_commit_pc_arrived !== 1'b0) begin n_fail++; $display("FAIL nt_early: got arr=%0b want 0", rob_commit_pc_arrived); end
    step();
    n_tests++; if (rob_commit_pc_arrived !== 1'b1 || rob_commit_pc !== 32'h100) begin n_fail++; $display("FAIL nt_commit: got arr=%0b pc=%h want 1 00000100", rob_commit_pc_arrived, rob_commit_pc); end
    n_tests++; if (hit_res !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL nt_hit: got hit=%0b fl=%0b want 1 0", hit_res, flush); end
    step();
    n_tests++; if (rob_commit_pc_arrived !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL nt_after: got arr=%0b cnt=%0d want 0 0", rob_commit_pc_arrived, count); end
  endtask

  task automatic test_mispredict();
    set_enq(1, 32'h200, 32'h204, 4'd1); step();
    for (int i = 0; i < 3; i++) begin
      set_enq(1, 32'h204 + 32'(4*i), 32'h208 + 32'(4*i), 4'(5+i)); step();
    end
    set_enq(0, 0, 0, 0);
    set_res(1, 4'd1, 1, 32'h180); step(); set_res(0, 0, 0, 0);
    n_tests++; if (rob_commit_pc_arrived !== 1'b0 || count !== 5'd4) begin n_fail++; $display("FAIL mp_early: got arr=%0b cnt=%0d want 0 4", rob_commit_pc_arrived, count); end
    step();
    n_tests++; if (rob_commit_pc_arrived !== 1'b1 || hit_res !== 1'b0 || rob_commit_pc !== 32'h200) begin n_fail++; $display("FAIL mp_commit: got arr=%0b hit=%0b pc=%h want 1 0 00000200", rob_commit_pc_arrived, hit_res, rob_commit_pc); end
    n_tests++; if (flush !== 1'b1 || redirect_pc !== 32'h180) begin n_fail++; $display("FAIL mp_flush: got fl=%0b pc=%h want 1 00000180", flush, redirect_pc); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL mp_count: got %0d want 0", count); end
    step();
    n_tests++; if (flush !== 1'b0 || rob_commit_pc_arrived !== 1'b0) begin n_fail++; $display("FAIL mp_pulse: got fl=%0b arr=%0b want 0 0", flush, rob_commit_pc_arrived); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      set_enq(1, 32'h300 + 32'(4*i), 32'h304 + 32'(4*i), 4'(i)); step();
    end
    set_enq(0, 0, 0, 0);
    for (int i = 2; i >= 0; i--) begin
      set_res(1, 4'(i), 0, 0); step();
      n_tests++; if (rob_commit_pc_arrived !== 1'b0) begin n_fail++; $display("FAIL ooo_stall%0d: got arr=%0b want 0", i, rob_commit_pc_arrived); end
    end
    set_res(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = 32'h300 + 32'(4*i);
      n_tests++; if (rob_commit_pc_arrived !== 1'b1 || rob_commit_pc !== exp_pc || hit_res !== 1'b1) begin n_fail++; $display("FAIL ooo_commit%0d: got arr=%0b pc=%h hit=%0b want 1 %h 1", i, rob_commit_pc_arrived, rob_commit_pc, hit_res, exp_pc); end
    end
    step();
    n_tests++; if (rob_commit_pc_arrived !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL ooo_end: got arr=%0b cnt=%0d want 0 0", rob_commit_pc_arrived, count); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_pcs[$];
    int m;
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(1, 32'h1000 + 32'(16*i), 32'h1004 + 32'(16*i), 4'(i)); step();
    end
    n_tests++; if (full !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL fw_full: got full=%0b cnt=%0d want 1 16", full, count); end
    set_enq(1, 32'hBAD0, 32'hBAD4, 4'd0); step();
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL fw_drop17: got cnt=%0d want 16", count); end
    set_enq(0, 0, 0, 0);
    set_res(1, 4'd0, 0, 0); step(); set_res(0, 0, 0, 0);
    // Commit edge: the queue was full going in, so this enqueue is refused.
    set_enq(1, 32'hBAD0, 32'hBAD4, 4'd0); step();
    n_tests++; if (rob_commit_pc_arrived !== 1'b1 || rob_commit_pc !== 32'h1000 || count !== 5'd15) begin n_fail++; $display("FAIL fw_commit: got arr=%0b pc=%h cnt=%0d want 1 00001000 15", rob_commit_pc_arrived, rob_commit_pc, count); end
    set_enq(1, 32'h2000, 32'h2004, 4'd0); step(); set_enq(0, 0, 0, 0);
    n_tests++; if (full !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL fw_refill: got full=%0b cnt=%0d want 1 16", full, count); end
    for (int i = 1; i < DEPTH; i++) exp_pcs.push_back(32'h1000 + 32'(16*i));
    exp_pcs.push_back(32'h2000);
    m = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < DEPTH) set_res(1, 4'((c + 1) % DEPTH), 0, 0); else set_res(0, 0, 0, 0);
      step();
      if (rob_commit_pc_arrived === 1'b1) begin
        n_tests++; if (m >= DEPTH || rob_commit_pc !== exp_pcs[m]) begin n_fail++; $display("FAIL fw_drain%0d: got pc=%h want %h", m, rob_commit_pc, (m < DEPTH) ? exp_pcs[m] : 32'hX); end
        m++;
      end
    end
    n_tests++; if (m !== DEPTH || count !== 5'd0) begin n_fail++; $display("FAIL fw_drained: got commits=%0d cnt=%0d want 16 0", m, count); end
  endtask

  task automatic test_priority_pause();
    set_enq(1, 32'h400, 32'h404, 4'd4); step();
    set_enq(1, 32'h404, 32'h408, 4'd5); step(); set_enq(0, 0, 0, 0);
    set_res(1, 4'd4, 0, 0); step(); set_res(0, 0, 0, 0);
    ext_flush = 1'b1; step(); ext_flush = 1'b0;
    n_tests++; if (rob_commit_pc_arrived !== 1'b0 || flush !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL pr_extflush: got arr=%0b fl=%0b cnt=%0d want 0 0 0", rob_commit_pc_arrived, flush, count); end
    step();
    n_tests++; if (rob_commit_pc_arrived !== 1'b0) begin n_fail++; $display("FAIL pr_late: got arr=%0b want 0", rob_commit_pc_arrived); end
    set_enq(1, 32'h500, 32'h580, 4'd6); step(); set_enq(0, 0, 0, 0);
    set_res(1, 4'd6, 1, 32'h580); step(); set_res(0, 0, 0, 0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (rob_commit_pc_arrived !== 1'b0 || count !== 5'd1) begin n_fail++; $display("FAIL pr_pause%0d: got arr=%0b cnt=%0d want 0 1", i, rob_commit_pc_arrived, count); end
    end
    rdy = 1'b1; step();
    n_tests++; if (rob_commit_pc_arrived !== 1'b1 || rob_commit_pc !== 32'h500 || hit_res !== 1'b1) begin n_fail++; $display("FAIL pr_resume: got arr=%0b pc=%h hit=%0b want 1 00000500 1", rob_commit_pc_arrived, rob_commit_pc, hit_res); end
    step();
    n_tests++; if (rob_commit_pc_arrived !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL pr_once: got arr=%0b cnt=%0d want 0 0", rob_commit_pc_arrived, count); end
  endtask

  function automatic logic [3:0] pick_tag();
    int s;
    bit used;
    s = $urandom_range(0, 15);
    for (int k = 0; k < 16; k++) begin
      used = 0;
      foreach (mq[j]) if (mq[j].tag == 4'((s + k) % 16)) used = 1;
      if (!used) return 4'((s + k) % 16);
    end
    return 4'(s);
  endfunction

  task automatic test_random();
    int          open[$];
    int          p;
    logic [31:0] pc;
    logic [31:0] pred;
    for (int c = 0; c < 600; c++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      ext_flush = ($urandom_range(0, 59) == 0);
      pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      pred = ($urandom_range(0, 1) == 0) ? pc + 32'd4 : pc + (32'($urandom_range(2, 64)) << 2);
      set_enq($urandom_range(0, 2) != 0, pc, pred, pick_tag());
      open.delete();
      foreach (mq[j]) if (!mq[j].res) open.push_back(j);
      if (open.size() > 0 && $urandom_range(0, 9) < 7) begin
        p = open[$urandom_range(0, open.size() - 1)];
        if ($urandom_range(0, 19) < 17)
          set_res(1, mq[p].tag, mq[p].pred != mq[p].pc + 32'd4, mq[p].pred);
        else
          set_res(1, mq[p].tag, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC);
      end else begin
        set_res($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 1'b1, 32'h40);
      end
      step();
      n_tests++; if (count !== 5'(mq.size()) || full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_count c%0d: got cnt=%0d full=%0b want %0d %0b", c, count, full, mq.size(), mq.size() == DEPTH); end
      n_tests++; if (rob_commit_pc_arrived !== e_arr || flush !== e_flush) begin n_fail++; $display("FAIL rnd_pulse c%0d: got arr=%0b fl=%0b want %0b %0b", c, rob_commit_pc_arrived, flush, e_arr, e_flush); end
      if (e_arr) begin
        n_tests++; if (rob_commit_pc !== e_pc || hit_res !== e_hit) begin n_fail++; $display("FAIL rnd_commit c%0d: got pc=%h hit=%0b want %h %0b", c, rob_commit_pc, hit_res, e_pc, e_hit); end
      end
      if (e_flush) begin
        n_tests++; if (redirect_pc !== e_redir) begin n_fail++; $display("FAIL rnd_redirect c%0d: got %h want %h", c, redirect_pc, e_redir); end
      end
    end
    rdy = 1'b1; ext_flush = 1'b0;
    set_enq(0, 0, 0, 0); set_res(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_not_taken();
    test_mispredict();
    test_out_of_order();
    test_full_wrap();
    test_priority_pause();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every predicted control-flow instruction (B-type and JAL) from fetch until in-order commit. It records the fetch-time prediction, takes the execution result from the ALU/CDB, and at commit does two things: reports `pc` and prediction outcome to the two-bit branch predictor, and raises a flush/redirect to the fetcher on a mispredict. It sits between the fetcher/issue stage, the ALU result bus and the predictor's ROB-side training port.

## Interface
Parameters:
- `DEPTH`, 16 — entries; power of two.
- `PTR_W`, 4 — log2(`DEPTH`).
- `TAG_W`, 4 — width of the ROB tag carried by each entry.

Ports:
- `clk`  in  1  — the design's only clock; all state on rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `rdy`  in  1  — global ready; low = pause.
- `ext_flush`  in  1  — global pipeline flush from ROB (exception or other redirect).
- `enq_valid`  in  1  — a predicted instruction is being dispatched.
- `enq_pc`  in  32  — its PC.
- `enq_pred_taken`  in  1  — predictor's taken decision.
- `enq_pred_pc`  in  32  — predicted next PC.
- `enq_tag`  in  TAG_W  — ROB tag; unique among in-flight entries.
- `full`  out  1  — combinational; `count == DEPTH`.
- `count`  out  PTR_W+1  — occupied entries.
- `res_valid`  in  1  — ALU result for a control instruction.
- `res_tag`  in  TAG_W  — tag of the resolved instruction.
- `res_taken`  in  1  — actual direction (1 for JAL).
- `res_target`  in  32  — actual taken target.
- `rob_commit_pc_arrived`  out  1  — one-cycle training pulse to the predictor.
- `rob_commit_pc`  out  32  — PC of the committed entry.
- `hit_res`  out  1  — 1 = prediction correct.
- `flush`  out  1  — one-cycle mispredict pulse to the fetcher and ROB.
- `redirect_pc`  out  32  — correct next PC; valid while `flush` = 1.

## Operation
- **Storage.** Circular buffer with `head`/`tail` pointers that wrap modulo `DEPTH`.
  - Entry fields: `valid`, `resolved`, `pc`, `pred_pc`, `tag`, `act_pc`.
- **Enqueue.** Accepted when `enq_valid && !full`, with no flush and no `ext_flush` in the same cycle.
  - Write the entry at `tail` with `resolved = 0`, then advance `tail`.
  - `enq_valid` while `full` is dropped silently. The issue stage must stall on `full`.
- **Resolve.** When `res_valid`, search all entries with `valid && !resolved && tag == res_tag`.
  - On a match:
    - `act_pc = res_taken ? res_target : pc + 4`, computed modulo 2^32.
    - Set `resolved = 1`.
  - No match: ignored.
  - Multiple matches are illegal; if they occur, the lowest index wins.
- **Commit.** When the head entry has `valid && resolved`:
  - Register `rob_commit_pc_arrived = 1`, `rob_commit_pc = pc`, `hit_res = (act_pc == pred_pc)`.
  - Advance `head`.
- **Mispredict** (`hit_res = 0`), in the same registered cycle:
  - `flush = 1` and `redirect_pc = act_pc`.
  - All `valid` bits cleared, `head = tail = 0`, `count = 0`.
- **Commit rate.** At most one commit per cycle.
- **`ext_flush`.** Highest priority. Clears all entries and pointers, suppresses any commit that cycle, and drops enqueue and resolve.
- **Pause.** `rdy` low freezes all state and forces pulse outputs to 0 on the next edge.
- **Reset values.** All outputs are 0 at reset: `rob_commit_pc_arrived`, `hit_res`, `flush`, `rob_commit_pc`, `redirect_pc`. Also `count = 0` and `full = 0`. Reset clears all `valid` bits and pointers.

## Timing
- **Enqueue to visibility.** An entry enqueued at edge E is visible in `count` after E.
- **Resolve to commit.** Resolve sampled at edge E writes the entry. If that entry is at head, commit outputs are registered at E+1 and high during the cycle after E+1. Minimum resolve-to-pulse latency is 2 edges.
- **Pulse width.** `rob_commit_pc_arrived` and `flush` last exactly one cycle each unless the next head commits back-to-back.
- **Simultaneous events:**
  - Enqueue and hit-commit in one cycle: both happen; `count` is unchanged.
  - Enqueue while `full` with a commit in the same cycle: rejected. `full` is evaluated before the commit.
  - Resolve of the head entry and its commit never occur in the same edge.
  - Enqueue in a mispredict-commit cycle: dropped; the fetcher is redirected anyway.
  - Resolve targeting a younger entry during a mispredict cycle: dropped.
- **Ordering.** Out-of-order resolves are allowed. Commit stalls until the head is resolved, even when younger entries are resolved.
- **Reset mid-operation.** `rst_n` low asynchronously clears the queue and outputs immediately, including an in-progress pulse.

## Test plan
- **Reset.** Assert `rst_n = 0` mid-run with 5 entries queued -> `count = 0`, `flush = 0` and `rob_commit_pc_arrived = 0` immediately; a later commit requires new enqueues.
- **Correct not-taken prediction.** Enqueue pc `0x100`, pred_pc `0x104`, tag 3; resolve tag 3 with taken = 0 -> 2 edges later a one-cycle pulse with `rob_commit_pc = 0x100`, `hit_res = 1`, `flush = 0`.
- **Mispredict with younger entries.** Enqueue pc `0x200` (pred_pc `0x204`, tag 1) plus 3 younger entries; resolve tag 1 with taken = 1, target `0x180` -> `hit_res = 0`, `flush = 1`, `redirect_pc = 0x180`, `count = 0` next cycle.
- **Out-of-order resolve.** Enqueue tags 0,1,2; resolve 2, then 1, then 0 -> three commits in order pc0, pc1, pc2 on consecutive cycles after tag 0 resolves.
- **Full and wrap-around.** Fill 16 entries -> `full = 1`; a 17th enqueue is dropped. Commit one and enqueue next cycle -> `tail` wraps to index 0 and the entry commits correctly later.
- **Priority and pause.** `ext_flush` in the same cycle as a head commit -> no pulse, queue empty. `rdy = 0` for 3 cycles while the head is resolved -> no pulse until `rdy` returns, then exactly one.
